serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 68 ++++++
 tb/tb_serial_subtractor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a-b, one bit per clock, LSB first
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr;
    logic [CW-1:0]    cnt;
    logic             br, br_nx, d, last, zero_r;

    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ br;
        br_nx    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        last     = cnt == CW'(WIDTH - 1);
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                   (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        busy     = state == RUN;
        done     = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            zero_r <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= 1'b0;
            cnt    <= '0;
            zero_r <= 1'b0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            d_sr <= {d, d_sr[WIDTH-1:1]};
            br   <= br_nx;
            cnt  <= cnt + 1'b1;
            // zero is latched once so it stays valid while diff is held
            if (last) zero_r <= ({d, d_sr[WIDTH-1:1]} == '0);
        end
    end

    assign diff = d_sr;
    assign bout = br;
    assign zero = zero_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized check of serial_subtractor against plain arithmetic
module tb_serial_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, start, busy, done, bout, zero;
    logic [W-1:0] a, b, diff;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int abort_at);
        logic [W-1:0] ed;
        int           k, busy_n;
        bit           seen;
        ed = x - y;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        busy_n = 0; seen = 1'b0;
        for (k = 1; k <= 3 * W; k++) begin
            @(negedge clk);
            // inputs wander after acceptance; the result must not care
            start = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            if (abort_at == k) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0; start = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_diff", diff, 0);
                check("abort_bout", bout, 0);
                check("abort_zero", zero, 0);
                repeat (2 * W) begin
                    @(negedge clk);
                    if (done) seen = 1'b1;
                end
                check("abort_no_done", seen, 0);
                return;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
        end
        start = 1'b0;
        if (!seen) begin
            check("timeout", 0, 1);
            return;
        end
        check("latency", k, W + 1);
        check("busy_cycles", busy_n, W);
        check("diff", diff, ed);
        check("bout", bout, x < y);
        check("zero", zero, ed == 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("hold_diff", diff, ed);
        check("hold_bout", bout, x < y);
        check("hold_zero", zero, ed == 0);
    endtask

    initial begin
        int prev, pulses, k;
        bit got;
        reset = 1'b1; start = 1'b1; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_zero", zero, 0);
        reset = 1'b0;
        @(negedge clk);
        check("start_after_reset", busy, 1);
        start = 1'b0;
        got = 1'b0;
        for (k = 0; k < 3 * W && !got; k++) begin
            @(negedge clk);
            got = done;
        end
        check("first_done", got, 1);
        check("first_zero", zero, 1);
        @(negedge clk);

        run_op(4'd9, 4'd3, 0);
        run_op(4'd3, 4'd9, 0);
        run_op(4'd0, 4'd1, 0);
        run_op(4'd7, 4'd7, 0);
        run_op(4'd0, 4'd0, 0);
        run_op(4'd15, 4'd0, 0);
        run_op(4'd9, 4'd3, 2);
        run_op(4'd9, 4'd3, 0);
        for (int i = 0; i < 60; i++)
            run_op(W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W)) : 0);

        @(negedge clk);
        a = 4'd5; b = 4'd2; start = 1'b1;
        prev = -1; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_diff", diff, 3);
                check("b2b_bout", bout, 0);
                if (prev >= 0) check("b2b_period", i - prev, 6);
                prev = i;
                pulses++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
